pattern_receiver: RTL
=====================

# pattern_receiver

Serial capture-and-check block at the far end of the generator's static/dynamic pattern link. It deserializes the MSB-first bit stream framed by SELDYN or SELSTAT and compares each complete frame against the expected dynamic (16-bit) or static (88-bit) word. It reports per-frame completion, match status and a saturating error count to the test/debug logic.

## Interface

- SIZESRDYN, 16, dynamic frame length in bits
- SIZESRSTAT, 88, static frame length in bits
- EXPDYN, 16'hABCD, expected dynamic word
- EXPSTAT, 88'h123456789ABCDEF1234567, expected static word
- ERRW, 8, error counter width
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- SDI  in  1  serial data from generator, MSB first
- SELDYN  in  1  dynamic frame select, high for the whole frame
- SELSTAT  in  1  static frame select, high for the whole frame
- DYN_OUT  out  SIZESRDYN  last complete dynamic word
- STAT_OUT  out  SIZESRSTAT  last complete static word
- DONE_DYN  out  1  one-cycle pulse, dynamic frame complete
- DONE_STAT  out  1  one-cycle pulse, static frame complete
- MATCH  out  1  result of last complete frame compare
- ABORT  out  1  one-cycle pulse, frame terminated abnormally
- ERR_CNT  out  ERRW  saturating count of mismatches plus aborts

## Operation

- Select decode: {SELDYN,SELSTAT} = 10 dynamic, 01 static, 00 idle, 11 illegal.
- FSM states: IDLE, RX, DRAIN.
- IDLE: on edge with legal single select, shift SDI into internal shift register (bit 1), latch mode (DYN/STAT), bit count = 1, go RX. Select 11 in IDLE: ignored, stay IDLE, no error.
- RX: each edge with latched select still high and other select low: shreg <= {shreg[N-2:0], SDI}, count+1. N = SIZESRDYN or SIZESRSTAT per mode. Bit counter 7 bits (covers 88).
- Frame complete on edge capturing bit N: load DYN_OUT or STAT_OUT with full word, MATCH <= (word == EXP*), DONE_* pulse, ERR_CNT+1 if mismatch; go DRAIN if select still high next cycle, else IDLE.
- DRAIN: extra bits while select held high are discarded; no error. Return to IDLE when both selects low.
- Abort in RX: latched select drops before bit N, or other select rises (11). ABORT pulse, ERR_CNT+1, outputs DYN_OUT/STAT_OUT/MATCH unchanged, count cleared. Drop -> IDLE; 11 -> DRAIN.
- Mode switch 10->01 directly in RX is an abort (select drop); new frame starts only from IDLE.
- ERR_CNT saturates at all-ones; mismatch and abort in same cycle impossible by construction.
- Reset mid-frame: partial frame discarded, all state cleared.

## Timing

- Reset values: DYN_OUT 0, STAT_OUT 0, DONE_DYN 0, DONE_STAT 0, MATCH 0, ABORT 0, ERR_CNT 0, FSM IDLE.
- SDI sampled on the same edge as the generator shifts; SDI valid for a full cycle before each edge.
- Frame of N bits occupies N edges with select high; DONE_*, DYN_OUT/STAT_OUT, MATCH updated registered, visible the cycle after edge N (latency 1 from last bit).
- ABORT visible cycle after the edge that sees the select fault; ERR_CNT updates same cycle as DONE_*/ABORT.
- Back-to-back frames need at least one idle cycle (both selects low) between them.

## Test plan

- Reset then 16 cycles SELDYN=1 driving 16'hABCD MSB first -> cycle 17: DONE_DYN=1 for one cycle, DYN_OUT=16'hABCD, MATCH=1, ERR_CNT=0.
- 88 cycles SELSTAT=1 driving EXPSTAT with bit 0 flipped -> DONE_STAT pulse, STAT_OUT=88'h123456789ABCDEF1234566, MATCH=0, ERR_CNT=1.
- SELDYN high 10 cycles then low -> ABORT pulse, no DONE_DYN, DYN_OUT and MATCH unchanged, ERR_CNT+1.
- SELDYN high, SELSTAT raised at bit 5 -> ABORT, FSM DRAIN until both low; subsequent clean 0xABCD frame -> MATCH=1.
- SELDYN held 20 cycles with 0xABCD first -> DONE_DYN at bit 16 only, no ABORT, ERR_CNT unchanged.
- RST_N low at bit 40 of static frame, 300 mismatching frames with ERRW=8 -> all outputs 0 after reset; ERR_CNT stops at 255.

Source files
------------

// File: rtl/pattern_receiver_if.sv
// ============================================================================
// pattern_receiver_if : serial pattern link plus capture/check result bus
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface pattern_receiver_if #(
  parameter int SIZESRDYN  = 16,
  parameter int SIZESRSTAT = 88,
  parameter int ERRW       = 8
);
  logic                  SDI;
  logic                  SELDYN;
  logic                  SELSTAT;
  logic [SIZESRDYN-1:0]  DYN_OUT;
  logic [SIZESRSTAT-1:0] STAT_OUT;
  logic                  DONE_DYN;
  logic                  DONE_STAT;
  logic                  MATCH;
  logic                  ABORT;
  logic [ERRW-1:0]       ERR_CNT;

  modport master (
    output SDI, SELDYN, SELSTAT,
    input  DYN_OUT, STAT_OUT, DONE_DYN, DONE_STAT, MATCH, ABORT, ERR_CNT
  );

  modport slave (
    input  SDI, SELDYN, SELSTAT,
    output DYN_OUT, STAT_OUT, DONE_DYN, DONE_STAT, MATCH, ABORT, ERR_CNT
  );
endinterface

`default_nettype wire

// File: rtl/pattern_receiver.sv
// ============================================================================
// pattern_receiver : deserializes SELDYN/SELSTAT framed MSB-first frames and
//                    checks them against the expected dynamic/static words
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_receiver #(
  parameter int                    SIZESRDYN  = 16,
  parameter int                    SIZESRSTAT = 88,
  parameter logic [SIZESRDYN-1:0]  EXPDYN     = 16'hABCD,
  parameter logic [SIZESRSTAT-1:0] EXPSTAT    = 88'h123456789ABCDEF1234567,
  parameter int                    ERRW       = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  pattern_receiver_if.slave link
);

  localparam int         CNTW        = 7;
  localparam [CNTW-1:0]  C_LEN_DYN   = CNTW'(SIZESRDYN);
  localparam [CNTW-1:0]  C_LEN_STAT  = CNTW'(SIZESRSTAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RX    = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    mode_q, mode_d;   // 0 = dynamic, 1 = static
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic [SIZESRSTAT-1:0]   shreg_q, shreg_d;
  logic [SIZESRDYN-1:0]    dyn_out_q, dyn_out_d;
  logic [SIZESRSTAT-1:0]   stat_out_q, stat_out_d;
  logic                    done_dyn_q, done_dyn_d;
  logic                    done_stat_q, done_stat_d;
  logic                    match_q, match_d;
  logic                    abort_q, abort_d;
  logic [ERRW-1:0]         err_q, err_d;

  logic                    w_err_inc;
  logic                    w_own_sel;
  logic                    w_other_sel;
  logic [CNTW-1:0]         w_len;
  logic [SIZESRSTAT-1:0]   w_shift;
  logic                    w_match;

  // A single static-width register serves both modes; dynamic words occupy the low bits.
  assign w_shift     = {shreg_q[SIZESRSTAT-2:0], link.SDI};
  assign w_own_sel   = mode_q ? link.SELSTAT : link.SELDYN;
  assign w_other_sel = mode_q ? link.SELDYN  : link.SELSTAT;
  assign w_len       = mode_q ? C_LEN_STAT   : C_LEN_DYN;
  assign w_match     = mode_q ? (w_shift == EXPSTAT)
                              : (w_shift[SIZESRDYN-1:0] == EXPDYN);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    dyn_out_d   = dyn_out_q;
    stat_out_d  = stat_out_q;
    match_d     = match_q;
    done_dyn_d  = 1'b0;
    done_stat_d = 1'b0;
    abort_d     = 1'b0;
    w_err_inc   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (link.SELDYN ^ link.SELSTAT) begin
          shreg_d = {{(SIZESRSTAT-1){1'b0}}, link.SDI};
          mode_d  = link.SELSTAT;
          cnt_d   = CNTW'(1);
          state_d = S_RX;
        end
      end
      S_RX: begin
        if (!w_own_sel) begin
          abort_d   = 1'b1;
          w_err_inc = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else if (w_other_sel) begin
          abort_d   = 1'b1;
          w_err_inc = 1'b1;
          cnt_d     = '0;
          state_d   = S_DRAIN;
        end else begin
          shreg_d = w_shift;
          cnt_d   = cnt_q + CNTW'(1);
          if (cnt_d == w_len) begin
            // DRAIN exits on the first both-low edge, which also serves as the
            // mandatory gap cycle between frames.
            cnt_d     = '0;
            match_d   = w_match;
            w_err_inc = !w_match;
            state_d   = S_DRAIN;
            if (mode_q) begin
              stat_out_d  = w_shift;
              done_stat_d = 1'b1;
            end else begin
              dyn_out_d  = w_shift[SIZESRDYN-1:0];
              done_dyn_d = 1'b1;
            end
          end
        end
      end
      S_DRAIN: begin
        if (!link.SELDYN && !link.SELSTAT) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    err_d = err_q;
    if (w_err_inc && (err_q != {ERRW{1'b1}})) begin
      err_d = err_q + ERRW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      shreg_q     <= '0;
      dyn_out_q   <= '0;
      stat_out_q  <= '0;
      done_dyn_q  <= 1'b0;
      done_stat_q <= 1'b0;
      match_q     <= 1'b0;
      abort_q     <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      dyn_out_q   <= dyn_out_d;
      stat_out_q  <= stat_out_d;
      done_dyn_q  <= done_dyn_d;
      done_stat_q <= done_stat_d;
      match_q     <= match_d;
      abort_q     <= abort_d;
      err_q       <= err_d;
    end
  end

  assign link.DYN_OUT   = dyn_out_q;
  assign link.STAT_OUT  = stat_out_q;
  assign link.DONE_DYN  = done_dyn_q;
  assign link.DONE_STAT = done_stat_q;
  assign link.MATCH     = match_q;
  assign link.ABORT     = abort_q;
  assign link.ERR_CNT   = err_q;

endmodule

`default_nettype wire
